// File: rtl/sd_input_ctl.sv
// Sigma-delta input front-end: synchronises DSDIN/SDCLK, recovers one modulator bit per
// modulator clock (clocked, Manchester or internal strobe) and flags clock/decode faults.
module sd_input_ctl #(
  parameter int CLKTO_W = 8
) (
  input  logic       SYSCLK,
  input  logic       SYSRST,
  input  logic       DSDIN,
  input  logic       SDCLK,
  input  logic [1:0] reg_inmode,
  input  logic [3:0] reg_clkdiv,
  input  logic       reg_filten,
  output logic       bit_data,
  output logic       bit_valid,
  output logic       clk_fault,
  output logic       man_err,
  output logic [1:0] dbg_state
);

  // Handshake: bit_valid is a one-cycle push strobe with no back-pressure; bit_data is
  // meaningful only in a cycle where bit_valid=1 and the consumer must take it then.

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_GUARD = 2'd1,
    ST_WAIT  = 2'd2
  } man_state_t;

  localparam logic [1:0] MODE_RISE   = 2'd0;
  localparam logic [1:0] MODE_FALL   = 2'd1;
  localparam logic [1:0] MODE_MANCH  = 2'd2;
  localparam logic [1:0] MODE_STROBE = 2'd3;

  logic               dsd_s1, dsd_s2, dsd_s3;
  logic               sdc_s1, sdc_s2, sdc_s3;
  logic [1:0]         mode_q;
  man_state_t         state, state_n;
  logic [5:0]         man_cnt, man_cnt_n;
  logic [3:0]         div_cnt, div_cnt_n;
  logic [CLKTO_W-1:0] to_cnt, to_cnt_n;
  logic               data_n, valid_n, err_n, fault_n;

  logic       idle;
  logic       sdc_rise, sdc_fall, dsd_edge, clk_edge;
  logic [5:0] n_half, n_x3, guard_len, tmo_len;

  assign sdc_rise = sdc_s2 & ~sdc_s3;
  assign sdc_fall = ~sdc_s2 & sdc_s3;
  assign dsd_edge = dsd_s2 ^ dsd_s3;
  assign clk_edge = (reg_inmode == MODE_RISE) ? sdc_rise : sdc_fall;

  // A freshly changed mode gets one quiet cycle so stale counters never leak across modes.
  assign idle = !reg_filten || (reg_inmode != mode_q);

  // Manchester timing: half-bit N, guard window (3N/2)-1, timeout 2N-1 after a mid-bit edge.
  assign n_half    = (reg_clkdiv == 4'd0) ? 6'd2 : ({2'b00, reg_clkdiv} + 6'd1);
  assign n_x3      = n_half + {n_half[4:0], 1'b0};
  assign guard_len = {1'b0, n_x3[5:1]} - 6'd1;
  assign tmo_len   = {n_half[4:0], 1'b0} - 6'd1;

  assign dbg_state = state;

  always_comb begin
    state_n   = state;
    man_cnt_n = man_cnt;
    div_cnt_n = div_cnt;
    to_cnt_n  = to_cnt;
    data_n    = bit_data;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    if (idle) begin
      state_n   = ST_HUNT;
      man_cnt_n = '0;
      div_cnt_n = '0;
      to_cnt_n  = '0;
    end else begin
      if (reg_inmode != MODE_MANCH) begin
        state_n   = ST_HUNT;
        man_cnt_n = '0;
      end
      if (reg_inmode != MODE_STROBE) div_cnt_n = '0;
      if ((reg_inmode != MODE_RISE) && (reg_inmode != MODE_FALL)) to_cnt_n = '0;
      case (reg_inmode)
        MODE_RISE, MODE_FALL: begin
          if (clk_edge) begin
            valid_n = 1'b1;
            data_n  = dsd_s2;
          end
          if (sdc_rise || sdc_fall) to_cnt_n = '0;
          else if (!(&to_cnt)) to_cnt_n = to_cnt + {{(CLKTO_W-1){1'b0}}, 1'b1};
        end
        MODE_STROBE: begin
          // >= keeps the divider bounded if clkdiv is lowered mid-count.
          if (div_cnt >= reg_clkdiv) begin
            valid_n   = 1'b1;
            data_n    = dsd_s2;
            div_cnt_n = '0;
          end else begin
            div_cnt_n = div_cnt + 4'd1;
          end
        end
        default: begin
          case (state)
            ST_HUNT: begin
              man_cnt_n = '0;
              if (dsd_edge) begin
                valid_n = 1'b1;
                data_n  = dsd_s2;
                state_n = ST_GUARD;
              end
            end
            ST_GUARD: begin
              man_cnt_n = man_cnt + 6'd1;
              if (man_cnt == guard_len) state_n = ST_WAIT;
            end
            ST_WAIT: begin
              // A mid-bit edge landing on the timeout count is still a good bit.
              if (dsd_edge) begin
                valid_n   = 1'b1;
                data_n    = dsd_s2;
                man_cnt_n = '0;
                state_n   = ST_GUARD;
              end else if (man_cnt == tmo_len) begin
                err_n     = 1'b1;
                man_cnt_n = '0;
                state_n   = ST_HUNT;
              end else begin
                man_cnt_n = man_cnt + 6'd1;
              end
            end
            default: begin
              man_cnt_n = '0;
              state_n   = ST_HUNT;
            end
          endcase
        end
      endcase
    end
    fault_n = &to_cnt_n;
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      dsd_s1    <= 1'b0;
      dsd_s2    <= 1'b0;
      dsd_s3    <= 1'b0;
      sdc_s1    <= 1'b0;
      sdc_s2    <= 1'b0;
      sdc_s3    <= 1'b0;
      mode_q    <= 2'd0;
      state     <= ST_HUNT;
      man_cnt   <= '0;
      div_cnt   <= '0;
      to_cnt    <= '0;
      bit_data  <= 1'b0;
      bit_valid <= 1'b0;
      clk_fault <= 1'b0;
      man_err   <= 1'b0;
    end else begin
      dsd_s1    <= DSDIN;
      dsd_s2    <= dsd_s1;
      dsd_s3    <= dsd_s2;
      sdc_s1    <= SDCLK;
      sdc_s2    <= sdc_s1;
      sdc_s3    <= sdc_s2;
      mode_q    <= reg_inmode;
      state     <= state_n;
      man_cnt   <= man_cnt_n;
      div_cnt   <= div_cnt_n;
      to_cnt    <= to_cnt_n;
      bit_data  <= data_n;
      bit_valid <= valid_n;
      clk_fault <= fault_n;
      man_err   <= err_n;
    end
  end

endmodule
